// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam int unsigned FETCH_PC_W    = 32;
  localparam int unsigned FETCH_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SPACE,
    DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {pc, instr} entries with a single-cycle flush.
module riscv_fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = fetch_entry_t,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  input  logic             flush,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: sequential word fetch, fetch buffer, redirect flush.
// Define FETCH_STALL_CNT_EN to build the saturating memory stall counter.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned                  P_DATA_WIDTH      = 32,
  parameter int unsigned                  P_IMEM_ADDR_WIDTH = 32,
  parameter logic [P_IMEM_ADDR_WIDTH-1:0] P_RESET_PC        = '0,
  parameter int unsigned                  P_FIFO_DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [P_IMEM_ADDR_WIDTH-1:0] inst_addr,
  output logic                         inst_rd_en,
  input  logic [P_DATA_WIDTH-1:0]      instr_data,
  input  logic                         instr_ready,
  input  logic                         redirect_valid,
  input  logic [P_IMEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                         fetch_valid,
  output logic [P_DATA_WIDTH-1:0]      fetch_instr,
  output logic [P_IMEM_ADDR_WIDTH-1:0] fetch_pc,
  input  logic                         fetch_ready,
  output logic [31:0]                  stall_cnt
);

  localparam int unsigned CNT_W = $clog2(P_FIFO_DEPTH) + 1;
  localparam logic [P_IMEM_ADDR_WIDTH-1:0] PC_STEP    = P_IMEM_ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [P_IMEM_ADDR_WIDTH-1:0] ALIGN_MASK = ~P_IMEM_ADDR_WIDTH'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [P_IMEM_ADDR_WIDTH-1:0] pc;
    logic [P_DATA_WIDTH-1:0]      instr;
  } entry_t;

  fetch_state_e                 state_q, state_d;
  logic [P_IMEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [P_IMEM_ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
  logic                         inst_rd_en_q, inst_rd_en_d;

  entry_t           push_entry, head_entry;
  logic [CNT_W-1:0] fifo_count, count_after;
  logic             fifo_full, fifo_empty;
  logic             resp, push_en, pop_en, space_after;
  logic [P_IMEM_ADDR_WIDTH-1:0] redir_target, pc_seq;

  assign resp         = inst_rd_en_q && instr_ready;
  assign pop_en       = fetch_ready && !fifo_empty;
  assign push_en      = (state_q == REQ) && resp && !redirect_valid && !(fifo_full && !pop_en);
  assign count_after  = fifo_count + CNT_W'(push_en) - CNT_W'(pop_en);
  assign space_after  = (count_after < CNT_W'(P_FIFO_DEPTH));
  assign redir_target = redirect_pc & ALIGN_MASK;
  assign pc_seq       = pc_q + PC_STEP;
  assign push_entry   = '{pc: pc_q, instr: instr_data};

  riscv_fetch_fifo #(
    .DEPTH   (P_FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (pop_en),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_addr_d  = inst_addr_q;
    inst_rd_en_d = inst_rd_en_q;
    if (redirect_valid) begin
      pc_d = redir_target;
      // An unanswered request must stay on the bus; its data is dropped later.
      if (inst_rd_en_q && !instr_ready) begin
        state_d = DISCARD;
      end else begin
        state_d      = REQ;
        inst_rd_en_d = 1'b1;
        inst_addr_d  = redir_target;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = REQ;
          inst_rd_en_d = 1'b1;
          inst_addr_d  = pc_q;
        end
        REQ: begin
          if (resp) begin
            pc_d = pc_seq;
            if (space_after) begin
              inst_addr_d = pc_seq;
            end else begin
              state_d      = WAIT_SPACE;
              inst_rd_en_d = 1'b0;
            end
          end
        end
        WAIT_SPACE: begin
          if (space_after) begin
            state_d      = REQ;
            inst_rd_en_d = 1'b1;
            inst_addr_d  = pc_q;
          end
        end
        DISCARD: begin
          if (resp) begin
            state_d     = REQ;
            inst_addr_d = pc_q;
          end
        end
        default: begin
          state_d      = IDLE;
          inst_rd_en_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pc_q         <= P_RESET_PC;
      inst_addr_q  <= P_RESET_PC;
      inst_rd_en_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_addr_q  <= inst_addr_d;
      inst_rd_en_q <= inst_rd_en_d;
    end
  end

  assign inst_addr   = inst_addr_q;
  assign inst_rd_en  = inst_rd_en_q;
  assign fetch_valid = !fifo_empty;
  assign fetch_instr = head_entry.instr;
  assign fetch_pc    = head_entry.pc;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (inst_rd_en_q && !instr_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Scoreboard bench for riscv_fetch_unit: expected fetches and memory completions
// are queued per scenario and checked by a monitor running beside the stimulus.
module tb_riscv_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

`ifdef FETCH_STALL_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd3;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_addr;
  logic        inst_rd_en;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready = 1'b0;
  logic [31:0] stall_cnt;

  // Memory model: serves addresses below mem_limit, optionally stalls slow_addr.
  logic [31:0] mem_limit = '0;
  logic [31:0] slow_addr = '0;
  int unsigned slow_cycles = 0;
  int unsigned stall_seen;
  logic        ready_idle = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign instr_data  = {16'hC0DE, inst_addr[15:0]};
  assign instr_ready = (inst_rd_en || ready_idle) && (inst_addr < mem_limit)
                       && !((inst_addr == slow_addr) && (stall_seen < slow_cycles));

  always @(posedge clk or negedge reset) begin
    if (!reset) stall_seen <= 0;
    else if (inst_rd_en && instr_ready) stall_seen <= 0;
    else if (inst_rd_en && inst_addr == slow_addr) stall_seen <= stall_seen + 1;
  end

  riscv_fetch_unit #(
    .P_DATA_WIDTH      (32),
    .P_IMEM_ADDR_WIDTH (32),
    .P_RESET_PC        (32'h0000_0000),
    .P_FIFO_DEPTH      (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_addr      (inst_addr),
    .inst_rd_en     (inst_rd_en),
    .instr_data     (instr_data),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .stall_cnt      (stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_fetch(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = {16'hC0DE, pc[15:0]};
    exp_q.push_back(e);
  endtask

  task automatic exp_mem(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (reset && fetch_valid && fetch_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_fetch: got pc=%h instr=%h, required no transfer", fetch_pc, fetch_instr);
        end else begin
          e = exp_q.pop_front();
          check("sb_fetch_pc", fetch_pc, e.pc);
          check("sb_fetch_instr", fetch_instr, e.instr);
        end
      end
      if (reset && inst_rd_en && instr_ready) begin
        if (addr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_mem: got completion at %h, required none", inst_addr);
        end else begin
          a = addr_q.pop_front();
          check("sb_mem_addr", inst_addr, a);
        end
      end
    end
  endtask

  task automatic start(input logic [31:0] limit, input logic fr, input logic [31:0] saddr,
                       input int unsigned scyc, input logic ridle);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    mem_limit      = limit;
    fetch_ready    = fr;
    slow_addr      = saddr;
    slow_cycles    = scyc;
    ready_idle     = ridle;
    tick();
    tick();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rd_en"}, 32'(inst_rd_en), 32'd0);
    check({tag, "_addr"}, inst_addr, 32'h0);
    check({tag, "_valid"}, 32'(fetch_valid), 32'd0);
    check({tag, "_instr"}, fetch_instr, 32'h0);
    check({tag, "_pc"}, fetch_pc, 32'h0);
    check({tag, "_stall"}, stall_cnt, 32'h0);
  endtask

  task automatic drain(input string tag);
    check({tag, "_fetch_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_mem_left"}, 32'(addr_q.size()), 32'd0);
    exp_q.delete();
    addr_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Zero-wait memory, decode always ready.
    start(32'h10, 1'b1, 32'h0, 0, 1'b0);
    reset_checks("t1_reset");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_fetch(32'(4 * i));
      exp_mem(32'(4 * i));
    end
    tick();
    check("t1_e1_valid", 32'(fetch_valid), 32'd0);
    check("t1_e1_rd_en", 32'(inst_rd_en), 32'd1);
    check("t1_e1_addr", inst_addr, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_thru_valid", 32'(fetch_valid), 32'd1);
      check("t1_thru_pc", fetch_pc, 32'(4 * i));
      tick();
    end
    tick();
    drain("t1");

    // Three wait cycles on 0x4.
    start(32'hC, 1'b1, 32'h4, 3, 1'b0);
    reset = 1'b1;
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    exp_mem(32'h0);   exp_mem(32'h4);   exp_mem(32'h8);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t2_hold_rd_en", 32'(inst_rd_en), 32'd1);
      check("t2_hold_addr", inst_addr, 32'h4);
      tick();
    end
    check("t2_next_addr", inst_addr, 32'h8);
    check("t2_stall_cnt", stall_cnt, EXP_STALL);
    tick(); tick(); tick();
    drain("t2");

    // Decode back-pressure fills the buffer; stray instr_ready while idle.
    start(32'h20, 1'b0, 32'h0, 0, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_fetch(32'(4 * i));
      exp_mem(32'(4 * i));
    end
    tick(); tick(); tick();
    check("t3_full_rd_en", 32'(inst_rd_en), 32'd0);
    check("t3_full_valid", 32'(fetch_valid), 32'd1);
    check("t3_full_pc", fetch_pc, 32'h0);
    tick(); tick();
    check("t3_hold_rd_en", 32'(inst_rd_en), 32'd0);
    check("t3_hold_pc", fetch_pc, 32'h0);
    check("t3_hold_instr", fetch_instr, 32'hC0DE_0000);
    fetch_ready = 1'b1;
    tick();
    check("t3_resume_rd_en", 32'(inst_rd_en), 32'd1);
    check("t3_resume_addr", inst_addr, 32'h8);
    check("t3_resume_pc", fetch_pc, 32'h4);
    repeat (10) tick();
    ready_idle = 1'b0;
    drain("t3");

    // Redirect to unaligned 0x103 while 0x8 is outstanding.
    start(32'h8, 1'b1, 32'h0, 0, 1'b0);
    reset = 1'b1;
    exp_fetch(32'h0);
    exp_mem(32'h0); exp_mem(32'h4); exp_mem(32'h8);
    tick(); tick(); tick();
    fetch_ready = 1'b0;
    check("t4_pre_pc", fetch_pc, 32'h4);
    check("t4_pre_addr", inst_addr, 32'h8);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    check("t4_flush_valid", 32'(fetch_valid), 32'd0);
    check("t4_discard_addr", inst_addr, 32'h8);
    check("t4_discard_rd_en", 32'(inst_rd_en), 32'd1);
    fetch_ready = 1'b1;
    tick();
    check("t4_discard_addr2", inst_addr, 32'h8);
    exp_fetch(32'h100); exp_fetch(32'h104); exp_fetch(32'h108);
    exp_mem(32'h100);   exp_mem(32'h104);   exp_mem(32'h108);
    mem_limit = 32'h10C;
    tick();
    check("t4_target_addr", inst_addr, 32'h100);
    repeat (6) tick();
    drain("t4");

    // Redirect in the same cycle as the 0xC response.
    start(32'h208, 1'b1, 32'h0, 0, 1'b0);
    reset = 1'b1;
    exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8);
    exp_fetch(32'h200); exp_fetch(32'h204);
    exp_mem(32'h0); exp_mem(32'h4); exp_mem(32'h8); exp_mem(32'hC);
    exp_mem(32'h200); exp_mem(32'h204);
    repeat (4) tick();
    check("t5_pre_addr", inst_addr, 32'hC);
    check("t5_pre_pc", fetch_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("t5_flush_valid", 32'(fetch_valid), 32'd0);
    check("t5_target_addr", inst_addr, 32'h200);
    check("t5_target_rd_en", 32'(inst_rd_en), 32'd1);
    repeat (6) tick();
    drain("t5");

    // Asynchronous reset in the middle of an outstanding request.
    start(32'h8, 1'b1, 32'h0, 0, 1'b0);
    reset = 1'b1;
    exp_fetch(32'h0); exp_fetch(32'h4);
    exp_mem(32'h0);   exp_mem(32'h4);
    repeat (5) tick();
    check("t6_pre_rd_en", 32'(inst_rd_en), 32'd1);
    check("t6_pre_addr", inst_addr, 32'h8);
    #3;
    reset = 1'b0;
    #2;
    reset_checks("t6_async");
    tick();
    tick();
    reset = 1'b1;
    exp_fetch(32'h0); exp_fetch(32'h4);
    exp_mem(32'h0);   exp_mem(32'h4);
    tick();
    check("t6_restart_rd_en", 32'(inst_rd_en), 32'd1);
    check("t6_restart_addr", inst_addr, 32'h0);
    repeat (5) tick();
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core; sits directly upstream of the decode stage and drives the instruction-memory port (inst_addr / inst_rd_en / instr_data / instr_ready).
- Issues sequential word fetches and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Handles redirects (branch, jump, trap) by flushing the FIFO and any in-flight fetch.

Parameters:
- P_DATA_WIDTH, 32, instruction word width.
- P_IMEM_ADDR_WIDTH, 32, instruction address / PC width.
- P_RESET_PC, 32'h0000_0000, first fetch address after reset.
- P_FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2.

Ports:
- clk  input  1  core clock; all state on posedge.
- reset  input  1  asynchronous, active-low reset.
- inst_addr  output  P_IMEM_ADDR_WIDTH  fetch address; word aligned.
- inst_rd_en  output  1  fetch request valid.
- instr_data  input  P_DATA_WIDTH  fetched word; valid when instr_ready=1.
- instr_ready  input  1  memory completes the current request this cycle.
- redirect_valid  input  1  PC redirect request from execute.
- redirect_pc  input  P_IMEM_ADDR_WIDTH  redirect target.
- fetch_valid  output  1  FIFO head valid to decode.
- fetch_instr  output  P_DATA_WIDTH  FIFO head instruction.
- fetch_pc  output  P_IMEM_ADDR_WIDTH  FIFO head PC.
- fetch_ready  input  1  decode accepts the head this cycle.
- stall_cnt  output  32  memory stall cycle count (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=P_RESET_PC, FIFO empty, state=IDLE.
  - inst_rd_en=0, inst_addr=P_RESET_PC.
  - fetch_valid=0, fetch_instr=0, fetch_pc=0, stall_cnt=0.
- Memory protocol:
  - At most one outstanding request.
  - inst_rd_en and inst_addr are registered, and are held stable until a cycle with instr_ready=1.
  - The transfer completes in that cycle.
  - instr_ready while inst_rd_en=0 is ignored.
- FSM states:
  - IDLE: first cycle after reset release, no request.
    - Next state: REQ.
  - REQ: inst_rd_en=1, inst_addr=pc.
    - On instr_ready: push {pc, instr_data} and set pc+=4.
    - Stay in REQ if FIFO occupancy after this cycle's push/pop is below P_FIFO_DEPTH; otherwise go to WAIT_SPACE.
  - WAIT_SPACE: inst_rd_en=0.
    - Go to REQ when occupancy < P_FIFO_DEPTH.
  - DISCARD: entered on redirect while REQ is pending without instr_ready.
    - inst_rd_en stays 1 at the old address.
    - On instr_ready: drop the data and go to REQ at the new pc.
- Redirect (redirect_valid=1, has priority in every state):
  - FIFO flushed the same cycle; fetch_valid=0 the next cycle.
  - pc <= {redirect_pc[W-1:2], 2'b00}.
  - If instr_ready=1 in the same cycle, the returned data is dropped and the next state is REQ.
  - A redirect during DISCARD updates pc only.
- Latency: word returned in cycle N is visible on fetch_valid in cycle N+1 if the FIFO was empty.
- Throughput: one instruction per cycle with zero-wait memory and fetch_ready=1.
- FIFO:
  - Push and pop in the same cycle are allowed at any occupancy, including full with a pop.
  - Pointers wrap modulo P_FIFO_DEPTH.
  - The FIFO never overflows: a request is only issued when space is guaranteed.
- fetch_ready while fetch_valid=0 has no effect.
- fetch_instr and fetch_pc hold their value while fetch_valid=1 and fetch_ready=0.
- PC arithmetic wraps modulo 2^P_IMEM_ADDR_WIDTH.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- Defined: stall_cnt increments every cycle with inst_rd_en=1 and instr_ready=0.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
- Undefined: stall_cnt tied to 0 and no counter logic is generated.

Decomposition:
- Package riscv_fetch_pkg holds:
  - fetch_state_e enum {IDLE, REQ, WAIT_SPACE, DISCARD}.
  - fetch_entry_t struct {pc, instr}.
  - INSTR_BYTES=4 constant.
- Sub-module riscv_fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty.

Test Plan:
- Reset release with instr_ready always 1 and fetch_ready=1:
  - inst_addr sequence 0x0, 0x4, 0x8.
  - fetch_pc 0x0 first appears 2 cycles after reset release; one instruction per cycle after that.
- Memory wait of 3 cycles on 0x4:
  - inst_addr held at 0x4 with inst_rd_en=1 for 4 cycles.
  - With FETCH_STALL_CNT_EN, stall_cnt=3.
- fetch_ready=0 with zero-wait memory:
  - FIFO fills to 2 entries, then inst_rd_en=0.
  - Raising fetch_ready resumes fetch at the next sequential PC with no duplicate or lost PCs.
- Redirect to 0x103 while 0x8 is pending with no ready:
  - DISCARD state holds 0x8 until instr_ready; that data is dropped.
  - Next inst_addr is 0x100.
  - FIFO empty the cycle after the redirect.
- Redirect in the same cycle as instr_ready on 0xC:
  - 0xC is never presented.
  - Next inst_addr is the redirect target.
- Reset asserted mid-request with inst_rd_en=1:
  - All outputs go to reset values immediately, before the next clk edge.
  - Fetch restarts at P_RESET_PC.
